// File: rtl/card_dealer.sv
// Card source for the bell game: deals LFSR cards alternately to players A/B at a fixed cadence,
// tracks the table count and deck, and holds on a bell ring until scoring acknowledges.
module card_dealer #(
   parameter logic [15:0] DEAL_PERIOD = 16'd50000,
   parameter logic [7:0]  DECK_SIZE   = 8'd56,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       bell_i,
   input  logic       bell_done_i,
   input  logic       take_table_i,
   output logic [1:0] c1_o,
   output logic [2:0] n1_o,
   output logic [1:0] c2_o,
   output logic [2:0] n2_o,
   output logic       card_valid_o,
   output logic       turn_o,
   output logic [7:0] count_o,
   output logic [7:0] cards_left_o,
   output logic       game_over_o
);

   typedef enum logic [1:0] {S_IDLE, S_DEAL_WAIT, S_HOLD, S_DONE} state_t;

   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [1:0]  c1_q, c1_d, c2_q, c2_d;
   logic [2:0]  n1_q, n1_d, n2_q, n2_d;
   logic        card_valid_q, card_valid_d;
   logic        turn_q, turn_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  left_q, left_d;

   logic        launch, deal, tick_en, resume;
   logic [1:0]  card_col;
   logic [2:0]  card_num;
   logic        fb;

   // Card is taken from the LFSR value before it advances.
   assign card_col = lfsr_q[4:3];
   assign card_num = ((lfsr_q[2:0] >= 3'd5) ? (lfsr_q[2:0] - 3'd5) : lfsr_q[2:0]) + 3'd1;
   assign fb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE: if (start_i) state_d = S_DEAL_WAIT;
         S_DEAL_WAIT: begin
            if (bell_i)                          state_d = S_HOLD;
            else if (deal && left_q == 8'd1)     state_d = S_DONE;
         end
         S_HOLD: if (bell_done_i) state_d = (left_q == 8'd0) ? S_DONE : S_DEAL_WAIT;
         default: state_d = S_IDLE;
      endcase
   end

   // A bell on the deal edge wins: the deal strobe is suppressed entirely.
   always_comb begin
      game_over_o = (state_q == S_DONE);
      launch      = 1'b0;
      deal        = 1'b0;
      tick_en     = 1'b0;
      resume      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: launch = start_i;
         S_DEAL_WAIT: begin
            if (!bell_i) begin
               if (timer_q == DEAL_PERIOD - 16'd1) deal    = 1'b1;
               else                                tick_en = 1'b1;
            end
         end
         S_HOLD:  resume = bell_done_i;
         default: ;
      endcase
   end

   always_comb begin
      timer_d      = timer_q;
      lfsr_d       = lfsr_q;
      c1_d         = c1_q;
      n1_d         = n1_q;
      c2_d         = c2_q;
      n2_d         = n2_q;
      card_valid_d = 1'b0;
      turn_d       = turn_q;
      count_d      = count_q;
      left_d       = left_q;
      if (launch) begin
         timer_d = 16'd0;
         left_d  = DECK_SIZE;
         count_d = 8'd0;
         turn_d  = 1'b0;
      end
      if (tick_en) timer_d = timer_q + 16'd1;
      if (deal) begin
         if (!turn_q) begin
            c1_d = card_col;
            n1_d = card_num;
         end else begin
            c2_d = card_col;
            n2_d = card_num;
         end
         card_valid_d = 1'b1;
         count_d      = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
         left_d       = left_q - 8'd1;
         turn_d       = ~turn_q;
         timer_d      = 16'd0;
         lfsr_d       = {fb, lfsr_q[15:1]};
      end
      if (resume) begin
         timer_d = 16'd0;
         if (take_table_i) begin
            count_d = 8'd0;
            c1_d    = 2'd0;
            n1_d    = 3'd0;
            c2_d    = 2'd0;
            n2_d    = 3'd0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_q      <= 16'd0;
         lfsr_q       <= SEED_EFF;
         c1_q         <= 2'd0;
         n1_q         <= 3'd0;
         c2_q         <= 2'd0;
         n2_q         <= 3'd0;
         card_valid_q <= 1'b0;
         turn_q       <= 1'b0;
         count_q      <= 8'd0;
         left_q       <= DECK_SIZE;
      end else begin
         timer_q      <= timer_d;
         lfsr_q       <= lfsr_d;
         c1_q         <= c1_d;
         n1_q         <= n1_d;
         c2_q         <= c2_d;
         n2_q         <= n2_d;
         card_valid_q <= card_valid_d;
         turn_q       <= turn_d;
         count_q      <= count_d;
         left_q       <= left_d;
      end
   end

   assign c1_o         = c1_q;
   assign n1_o         = n1_q;
   assign c2_o         = c2_q;
   assign n2_o         = n2_q;
   assign card_valid_o = card_valid_q;
   assign turn_o       = turn_q;
   assign count_o      = count_q;
   assign cards_left_o = left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer: stimulus queues expected deals, a negedge monitor scores them.
module tb_card_dealer;

   localparam logic [15:0] DP   = 16'd4;
   localparam logic [7:0]  DECK = 8'd6;

   logic       clk, rst, start, bell, bell_done, take_table;
   logic [1:0] c1, c2;
   logic [2:0] n1, n2;
   logic       card_valid, turn, game_over;
   logic [7:0] count, cards_left;

   card_dealer #(.DEAL_PERIOD(DP), .DECK_SIZE(DECK), .SEED(16'hACE1)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .bell_i(bell),
      .bell_done_i(bell_done), .take_table_i(take_table),
      .c1_o(c1), .n1_o(n1), .c2_o(c2), .n2_o(n2),
      .card_valid_o(card_valid), .turn_o(turn), .count_o(count),
      .cards_left_o(cards_left), .game_over_o(game_over)
   );

   typedef struct {
      int cyc;
      bit who;
      int c;
      int n;
      int cnt;
      int left;
      bit trn;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   cyc  = 0;
   int   nvec = 0;
   int   nerr = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int dcyc, input bit who, input int c, input int n,
                       input int cnt, input int left, input bit trn);
      exp_t x;
      x.cyc = dcyc; x.who = who; x.c = c; x.n = n;
      x.cnt = cnt; x.left = left; x.trn = trn;
      q.push_back(x);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_c1"}, c1, 0);
      check({tag, "_n1"}, n1, 0);
      check({tag, "_c2"}, c2, 0);
      check({tag, "_n2"}, n2, 0);
      check({tag, "_valid"}, card_valid, 0);
      check({tag, "_turn"}, turn, 0);
      check({tag, "_count"}, count, 0);
      check({tag, "_left"}, cards_left, DECK);
      check({tag, "_game_over"}, game_over, 0);
   endtask

   // Monitor: every card_valid pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      if (card_valid) begin
         if (q.size() == 0) begin
            check("unexpected_card", 1, 0);
         end else begin
            e = q.pop_front();
            check("deal_cycle", cyc, e.cyc);
            check("deal_colour", e.who ? c2 : c1, e.c);
            check("deal_number", e.who ? n2 : n1, e.n);
            check("deal_count", count, e.cnt);
            check("deal_left", cards_left, e.left);
            check("deal_turn", turn, e.trn);
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; bell = 1'b0; bell_done = 1'b0; take_table = 1'b0;

      // T1 reset
      tick(3);
      check_reset_vals("reset");
      rst = 1'b0;
      tick(1);

      // T2 cadence: LFSR ACE1 -> 5670 -> AB38
      push(cyc + 5,  0, 0, 2, 1, 5, 1);
      push(cyc + 9,  1, 2, 1, 2, 4, 0);
      push(cyc + 13, 0, 3, 1, 3, 3, 1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(8);
      check("t2_count", count, 2);
      check("t2_turn", turn, 0);
      tick(4);

      // T3 bell and sweep; a second bell inside HOLD is ignored
      bell = 1'b1;
      tick(1);
      bell = 1'b0;
      tick(5);
      bell = 1'b1;
      tick(1);
      bell = 1'b0;
      tick(14);
      check("t3_hold_count", count, 3);
      bell_done = 1'b1; take_table = 1'b1;
      tick(1);
      bell_done = 1'b0; take_table = 1'b0;
      check("t3_swept_count", count, 0);
      check("t3_swept_n1", n1, 0);
      check("t3_swept_n2", n2, 0);
      check("t3_swept_c1", c1, 0);
      check("t3_pending_turn", turn, 1);
      push(cyc + 4, 1, 3, 5, 1, 2, 0);   // LFSR 559C
      tick(4);

      // T4 bell collides with the deal edge
      tick(3);
      bell = 1'b1;
      tick(1);
      bell = 1'b0;
      tick(5);
      check("t4_count", count, 1);
      check("t4_left", cards_left, 2);
      bell_done = 1'b1; take_table = 1'b0;
      tick(1);
      bell_done = 1'b0;
      check("t4_keep_c2", c2, 3);
      check("t4_keep_n2", n2, 5);
      check("t4_keep_n1", n1, 0);
      check("t4_keep_count", count, 1);

      // T5 exhaustion: LFSR 2ACE, 1567 (unchanged by the collision)
      push(cyc + 4, 0, 1, 2, 2, 1, 1);
      push(cyc + 8, 1, 0, 3, 3, 0, 0);
      tick(9);
      check("t5_game_over", game_over, 1);
      check("t5_left", cards_left, 0);
      bell = 1'b1;
      tick(1);
      bell = 1'b0; bell_done = 1'b1;
      tick(1);
      bell_done = 1'b0;
      tick(48);
      check("t5_still_over", game_over, 1);
      check("t5_table_held", count, 3);
      push(cyc + 5, 0, 2, 4, 1, 5, 1);   // LFSR 8AB3, not reseeded
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("t5_restart_over", game_over, 0);
      check("t5_restart_left", cards_left, DECK);
      check("t5_restart_count", count, 0);
      tick(4);

      // T6 reset during HOLD
      bell = 1'b1;
      tick(1);
      bell = 1'b0;
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_reset_vals("t6");
      bell_done = 1'b1; take_table = 1'b1;
      tick(1);
      bell_done = 1'b0; take_table = 1'b0;
      tick(20);
      check("t6_idle_count", count, 0);
      check("t6_idle_left", cards_left, DECK);

      // Reset reseeds: first card again comes from ACE1
      push(cyc + 5, 0, 0, 2, 1, 5, 1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(6);

      check("pending_deals", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
